fnd_scan_decoder: RTL and testbench

Passive monitor on the multiplexed 7-segment bus (`fnd_font`/`fnd_comm`) that reverses the display controller's work. It watches the active-low digit scan, waits for each digit select to settle, decodes the segment pattern back to a BCD nibble, and assembles the four digits into one frame. It sits beside the FND controller in the top level and feeds the UART reporter and the self-check logic with what is actually being displayed.

---
 rtl/fnd_pkg.sv | 61 ++++++
 rtl/fnd_scan_decoder_seg7_decode.sv | 38 +++
 rtl/fnd_scan_decoder.sv | 147 ++++++++++++++
 tb/tb_fnd_scan_decoder.sv | 237 +++++++++++++++++++++++
 4 files changed

// File: rtl/fnd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : fnd_pkg
// Description : Segment fonts, decoded codes and digit-select encodings shared
//               by the FND scan decoder.
// Revision    : 1.0  initial release
// ============================================================================
package fnd_pkg;

    // Active-low segment fonts, bit order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_0     = 7'h40;
    localparam logic [6:0] SEG_1     = 7'h79;
    localparam logic [6:0] SEG_2     = 7'h24;
    localparam logic [6:0] SEG_3     = 7'h30;
    localparam logic [6:0] SEG_4     = 7'h19;
    localparam logic [6:0] SEG_5     = 7'h12;
    localparam logic [6:0] SEG_6     = 7'h02;
    localparam logic [6:0] SEG_7     = 7'h78;
    localparam logic [6:0] SEG_8     = 7'h00;
    localparam logic [6:0] SEG_9     = 7'h10;
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    localparam logic [3:0] CODE_BLANK = 4'hF;
    localparam logic [3:0] CODE_ERR   = 4'hE;

    localparam logic [3:0] SEL_D0 = 4'b1110;
    localparam logic [3:0] SEL_D1 = 4'b1101;
    localparam logic [3:0] SEL_D2 = 4'b1011;
    localparam logic [3:0] SEL_D3 = 4'b0111;

    typedef struct packed {
        logic       valid;
        logic [1:0] idx;
    } sel_t;

    // Blanking (1111) and multi-low selects are reported as invalid.
    function automatic sel_t sel_decode(input logic [3:0] comm);
        sel_t s;
        s.valid = 1'b1;
        s.idx   = 2'd0;
        case (comm)
            SEL_D0:  s.idx = 2'd0;
            SEL_D1:  s.idx = 2'd1;
            SEL_D2:  s.idx = 2'd2;
            SEL_D3:  s.idx = 2'd3;
            default: s.valid = 1'b0;
        endcase
        return s;
    endfunction

    function automatic logic frame_has_err(input logic [15:0] frame);
        logic e;
        e = 1'b0;
        for (int i = 0; i < 4; i++) begin
            if (frame[4*i +: 4] == CODE_ERR) e = 1'b1;
        end
        return e;
    endfunction

endpackage
`default_nettype wire

// File: rtl/fnd_scan_decoder_seg7_decode.sv
`default_nettype none
// ============================================================================
// Module      : seg7_decode
// Description : Combinational inverse of the 7-segment font: pattern -> BCD.
// Revision    : 1.0  initial release
// ============================================================================
module seg7_decode
    import fnd_pkg::*;
(
    input  logic [6:0] i_seg,
    output logic [3:0] o_code,
    output logic       o_err
);

    always_comb begin
        o_code = CODE_ERR;
        o_err  = 1'b0;
        case (i_seg)
            SEG_0:     o_code = 4'd0;
            SEG_1:     o_code = 4'd1;
            SEG_2:     o_code = 4'd2;
            SEG_3:     o_code = 4'd3;
            SEG_4:     o_code = 4'd4;
            SEG_5:     o_code = 4'd5;
            SEG_6:     o_code = 4'd6;
            SEG_7:     o_code = 4'd7;
            SEG_8:     o_code = 4'd8;
            SEG_9:     o_code = 4'd9;
            SEG_BLANK: o_code = CODE_BLANK;
            default: begin
                o_code = CODE_ERR;
                o_err  = 1'b1;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: rtl/fnd_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : fnd_scan_decoder
// Description : Passive monitor that rebuilds the displayed 4-digit BCD frame
//               from the multiplexed active-low 7-segment scan bus.
// Revision    : 1.0  initial release
// ============================================================================
module fnd_scan_decoder
    import fnd_pkg::*;
#(
    parameter int SETTLE_CYC  = 4,
    parameter int TIMEOUT_CYC = 1_000_000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [7:0]  fnd_font,
    input  logic [3:0]  fnd_comm,
    output logic [15:0] digits,
    output logic [3:0]  dp,
    output logic        frame_valid,
    output logic        frame_changed,
    output logic        seg_err,
    output logic        stale
);

    localparam int SW = $clog2(SETTLE_CYC + 1);
    localparam int TW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [SW-1:0] c_settle_max  = SW'(SETTLE_CYC);
    localparam logic [SW-1:0] c_settle_last = SW'(SETTLE_CYC - 1);
    localparam logic [TW-1:0] c_timeout_max  = TW'(TIMEOUT_CYC);
    localparam logic [TW-1:0] c_timeout_last = TW'(TIMEOUT_CYC - 1);

    logic [7:0]    r_font_q;
    logic [3:0]    r_comm_q;
    logic [3:0]    r_comm_prev;
    logic [SW-1:0] r_settle;
    logic [TW-1:0] r_timeout;
    logic [15:0]   r_shadow;
    logic [3:0]    r_shadow_dp;
    logic [3:0]    r_seen;
    logic [15:0]   r_digits;
    logic [3:0]    r_dp;
    logic          r_frame_valid;
    logic          r_frame_changed;
    logic          r_seg_err;
    logic          r_stale;

    sel_t        w_sel;
    logic        w_comm_stable;
    logic        w_sample;
    logic [3:0]  w_code;
    logic        w_code_err;
    logic [15:0] w_shadow_nx;
    logic [3:0]  w_shadow_dp_nx;
    logic [3:0]  w_seen_nx;
    logic        w_frame_done;
    logic        w_timeout_hit;

    seg7_decode u_seg7_decode (
        .i_seg  (r_font_q[6:0]),
        .o_code (w_code),
        .o_err  (w_code_err)
    );

    assign w_sel         = sel_decode(r_comm_q);
    assign w_comm_stable = (r_comm_q == r_comm_prev);
    // Fires only on the counter's transition into saturation: one sample per dwell.
    assign w_sample      = w_sel.valid && w_comm_stable && (r_settle == c_settle_last);

    // Overwrite is folded in before completion so a re-hit completing sample is copied.
    always_comb begin
        w_shadow_nx    = r_shadow;
        w_shadow_dp_nx = r_shadow_dp;
        w_seen_nx      = r_seen;
        if (w_sample) begin
            w_shadow_nx[{w_sel.idx, 2'b00} +: 4] = w_code;
            w_shadow_dp_nx[w_sel.idx]            = ~r_font_q[7];
            w_seen_nx[w_sel.idx]                 = 1'b1;
        end
    end

    assign w_frame_done  = w_sample && (w_seen_nx == 4'hF);
    assign w_timeout_hit = !w_sample && (r_timeout == c_timeout_last);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_font_q        <= 8'hFF;
            r_comm_q        <= 4'hF;
            r_comm_prev     <= 4'hF;
            r_settle        <= '0;
            r_timeout       <= '0;
            r_shadow        <= 16'hFFFF;
            r_shadow_dp     <= 4'h0;
            r_seen          <= 4'h0;
            r_digits        <= 16'hFFFF;
            r_dp            <= 4'h0;
            r_frame_valid   <= 1'b0;
            r_frame_changed <= 1'b0;
            r_seg_err       <= 1'b0;
            r_stale         <= 1'b0;
        end else begin
            r_font_q    <= fnd_font;
            r_comm_q    <= fnd_comm;
            r_comm_prev <= r_comm_q;

            if (!w_sel.valid || !w_comm_stable) begin
                r_settle <= '0;
            end else if (r_settle != c_settle_max) begin
                r_settle <= r_settle + 1'b1;
            end

            if (w_sample) begin
                r_timeout <= '0;
                r_stale   <= 1'b0;
            end else if (w_timeout_hit) begin
                r_timeout <= c_timeout_max;
                r_stale   <= 1'b1;
            end else if (r_timeout != c_timeout_max) begin
                r_timeout <= r_timeout + 1'b1;
            end

            r_shadow    <= w_shadow_nx;
            r_shadow_dp <= w_shadow_dp_nx;
            r_seen      <= (w_frame_done || w_timeout_hit) ? 4'h0 : w_seen_nx;

            r_frame_valid   <= w_frame_done;
            r_frame_changed <= w_frame_done &&
                               ({w_shadow_dp_nx, w_shadow_nx} != {r_dp, r_digits});
            if (w_frame_done) begin
                r_digits  <= w_shadow_nx;
                r_dp      <= w_shadow_dp_nx;
                r_seg_err <= frame_has_err(w_shadow_nx);
            end else if (w_sample && w_code_err) begin
                r_seg_err <= 1'b1;
            end
        end
    end

    assign digits        = r_digits;
    assign dp            = r_dp;
    assign frame_valid   = r_frame_valid;
    assign frame_changed = r_frame_changed;
    assign seg_err       = r_seg_err;
    assign stale         = r_stale;

endmodule
`default_nettype wire

// File: tb/tb_fnd_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_fnd_scan_decoder
// Description : Scoreboard bench for fnd_scan_decoder with directed scans.
// Revision    : 1.0  initial release
// ============================================================================
module tb_fnd_scan_decoder;

    logic        clk = 1'b0;
    logic        rst;
    logic [7:0]  fnd_font;
    logic [3:0]  fnd_comm;
    logic [15:0] digits;
    logic [3:0]  dp;
    logic        frame_valid;
    logic        frame_changed;
    logic        seg_err;
    logic        stale;

    int checks   = 0;
    int failures = 0;

    typedef struct {
        logic [15:0] d;
        logic [3:0]  p;
        logic        ch;
        logic        err;
    } exp_t;

    exp_t sb[$];

    always #5 clk = ~clk;

    fnd_scan_decoder #(
        .SETTLE_CYC  (4),
        .TIMEOUT_CYC (100)
    ) dut (
        .clk           (clk),
        .rst           (rst),
        .fnd_font      (fnd_font),
        .fnd_comm      (fnd_comm),
        .digits        (digits),
        .dp            (dp),
        .frame_valid   (frame_valid),
        .frame_changed (frame_changed),
        .seg_err       (seg_err),
        .stale         (stale)
    );

    function automatic logic [6:0] seg7(input int v);
        case (v)
            0: return 7'h40;
            1: return 7'h79;
            2: return 7'h24;
            3: return 7'h30;
            4: return 7'h19;
            5: return 7'h12;
            6: return 7'h02;
            7: return 7'h78;
            8: return 7'h00;
            9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [7:0] fnt(input int v, input bit dp_lit);
        return {~dp_lit, seg7(v)};
    endfunction

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic show(input int idx, input logic [7:0] font, input int cyc);
        logic [3:0] sel;
        sel      = 4'hF;
        sel[idx] = 1'b0;
        fnd_comm = sel;
        fnd_font = font;
        tick(cyc);
    endtask

    task automatic blank(input int cyc);
        fnd_comm = 4'hF;
        fnd_font = 8'hFF;
        tick(cyc);
    endtask

    task automatic push(input logic [15:0] d, input logic [3:0] p, input logic ch, input logic err);
        exp_t e;
        e.d = d; e.p = p; e.ch = ch; e.err = err;
        sb.push_back(e);
    endtask

    task automatic drain(input string nm);
        tick(3);
        chk(nm, 32'(sb.size()), 32'd0);
    endtask

    task automatic chk_reset_state(input string tag);
        chk({tag, "_digits"}, 32'(digits), 32'hFFFF);
        chk({tag, "_dp"}, 32'(dp), 32'h0);
        chk({tag, "_frame_valid"}, 32'(frame_valid), 32'h0);
        chk({tag, "_frame_changed"}, 32'(frame_changed), 32'h0);
        chk({tag, "_seg_err"}, 32'(seg_err), 32'h0);
        chk({tag, "_stale"}, 32'(stale), 32'h0);
    endtask

    // Monitor: every frame_valid pulse must match the oldest queued expectation.
    always begin
        exp_t e;
        @(posedge clk);
        #1;
        if (frame_valid === 1'b1) begin
            if (sb.size() == 0) begin
                checks++;
                failures++;
                $display("FAIL unexpected_frame: got digits=%h dp=%h, no frame expected", digits, dp);
            end else begin
                e = sb.pop_front();
                chk("frame_digits", 32'(digits), 32'(e.d));
                chk("frame_dp", 32'(dp), 32'(e.p));
                chk("frame_changed", 32'(frame_changed), 32'(e.ch));
                chk("frame_seg_err", 32'(seg_err), 32'(e.err));
            end
        end else if (frame_changed !== 1'b0) begin
            chk("changed_without_valid", 32'(frame_changed), 32'h0);
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst      = 1'b1;
        fnd_comm = 4'hF;
        fnd_font = 8'hFF;
        tick(3);
        rst = 1'b0;
        tick(1);
        chk_reset_state("reset");

        // Steady scan of 1,2,3,4 then an identical repeat
        push(16'h4321, 4'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) show(i, fnt(i + 1, 0), 20);
        drain("steady_first_drain");
        push(16'h4321, 4'h0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) show(i, fnt(i + 1, 0), 20);
        drain("steady_repeat_drain");

        // Short glitches and blanking gaps must not produce samples
        push(16'h8765, 4'h0, 1'b1, 1'b0);
        show(0, fnt(5, 0), 20);
        blank(2);
        show(0, fnt(9, 0), 3);
        blank(2);
        show(1, fnt(6, 0), 20);
        show(3, fnt(9, 0), 3);
        show(2, fnt(7, 0), 20);
        blank(3);
        show(3, fnt(8, 0), 20);
        drain("glitch_drain");

        // Undecodable pattern on digit 2, blank on digit 3
        push(16'hFE21, 4'b0100, 1'b1, 1'b1);
        show(0, fnt(1, 0), 20);
        show(1, fnt(2, 0), 20);
        show(2, 8'h55, 20);
        chk("seg_err_sticky_mid_frame", 32'(seg_err), 32'h1);
        show(3, 8'hFF, 20);
        drain("bad_drain");
        push(16'h0000, 4'h0, 1'b1, 1'b0);
        for (int i = 0; i < 4; i++) show(i, fnt(0, 0), 20);
        drain("clean_drain");

        // Multi-low select is ignored; dp on digit 3
        push(16'h6789, 4'b1000, 1'b1, 1'b0);
        show(0, fnt(9, 0), 20);
        fnd_comm = 4'b1100;
        fnd_font = fnt(3, 1);
        tick(50);
        show(1, fnt(8, 0), 20);
        show(2, fnt(7, 0), 20);
        show(3, fnt(6, 1), 20);
        drain("multilow_drain");

        // Stall after two digits
        show(0, fnt(1, 0), 20);
        show(1, fnt(2, 0), 20);
        blank(75);
        chk("stale_before_timeout", 32'(stale), 32'h0);
        tick(20);
        chk("stale_after_timeout", 32'(stale), 32'h1);
        chk("stall_digits_held", 32'(digits), 32'h6789);
        chk("stall_dp_held", 32'(dp), 32'h8);
        show(2, fnt(3, 0), 20);
        chk("stale_cleared_by_sample", 32'(stale), 32'h0);
        show(3, fnt(4, 0), 20);
        push(16'h4321, 4'h0, 1'b1, 1'b0);
        show(0, fnt(1, 0), 20);
        show(1, fnt(2, 0), 20);
        drain("stall_resume_drain");

        // Reset after three digits
        show(0, fnt(7, 0), 20);
        show(1, fnt(7, 0), 20);
        show(2, fnt(7, 0), 20);
        blank(1);
        rst = 1'b1;
        tick(2);
        rst = 1'b0;
        tick(1);
        chk_reset_state("midreset");
        show(3, fnt(5, 0), 20);
        push(16'h5111, 4'h0, 1'b1, 1'b0);
        show(0, fnt(1, 0), 20);
        show(1, fnt(1, 0), 20);
        show(2, fnt(1, 0), 20);
        drain("midreset_drain");

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
`default_nettype wire
